// File: rtl/framebuffer_writer.sv
// Pixel write port into the framebuffer BRAM: input FIFO, (x, y) to linear address conversion,
// double buffering with deferred swap, hardware clear sweep, and write/drop counters.
module framebuffer_writer #(
    parameter int unsigned FRAME_WIDTH  = 512,
    parameter int unsigned FRAME_HEIGHT = 384,
    parameter int unsigned COORD_BITS   = 16,
    parameter int unsigned COLOR_WIDTH  = 16,
    parameter int unsigned ADDR_BITS    = 19,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pixel_valid_in,
    output logic                   pixel_ready_out,
    input  logic [COORD_BITS-1:0]  pixel_x_in,
    input  logic [COORD_BITS-1:0]  pixel_y_in,
    input  logic [COLOR_WIDTH-1:0] pixel_value_in,
    input  logic                   clear_req,
    input  logic [COLOR_WIDTH-1:0] clear_value,
    input  logic                   swap_req,
    output logic                   front_buffer,
    output logic                   swap_done,
    output logic                   busy_clearing,
    output logic                   bram_we,
    output logic [ADDR_BITS-1:0]   bram_addr,
    output logic [COLOR_WIDTH-1:0] bram_din,
    output logic [31:0]            write_count,
    output logic [15:0]            drop_count
);
    localparam int unsigned FRAME_SIZE = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int unsigned PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_BITS = 2 * COORD_BITS + COLOR_WIDTH;

    typedef enum logic {StIdle, StClear} state_e;
    state_e state_q, state_d;

    logic [ENTRY_BITS-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_BITS:0]      count_q;
    logic                   fifo_full, fifo_empty, push, pop;
    logic [COORD_BITS-1:0]  head_x, head_y;
    logic [COLOR_WIDTH-1:0] head_value;
    logic                   in_range;

    logic                   front_q, swap_pending_q, swap_done_q, do_swap;
    logic [COLOR_WIDTH-1:0] clear_val_q;
    logic [ADDR_BITS-1:0]   clear_cnt_q;
    logic                   clear_start, clear_last;
    logic [63:0]            base_full;

    logic                   bram_we_q, bram_we_d;
    logic [ADDR_BITS-1:0]   bram_addr_q, bram_addr_d;
    logic [COLOR_WIDTH-1:0] bram_din_q, bram_din_d;
    logic                   write_inc, drop_inc;
    logic [31:0]            write_count_q;
    logic [15:0]            drop_count_q;

    assign fifo_full       = (count_q == (PTR_BITS+1)'(FIFO_DEPTH));
    assign fifo_empty      = (count_q == '0);
    assign pixel_ready_out = !fifo_full;
    assign push            = pixel_valid_in && !fifo_full;

    assign {head_x, head_y, head_value} = fifo_mem[rd_ptr_q];
    assign in_range   = (64'(head_x) < 64'(FRAME_WIDTH)) && (64'(head_y) < 64'(FRAME_HEIGHT));
    // Writes always target the back buffer, i.e. the one the display is not reading.
    assign base_full  = front_q ? 64'd0 : 64'(FRAME_SIZE);
    assign clear_last = (clear_cnt_q == ADDR_BITS'(FRAME_SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (clear_req)  state_d = StClear;
            StClear: if (clear_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        do_swap     = 1'b0;
        clear_start = 1'b0;
        write_inc   = 1'b0;
        drop_inc    = 1'b0;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    clear_start = 1'b1;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (in_range) begin
                        bram_we_d   = 1'b1;
                        bram_addr_d = ADDR_BITS'(base_full + 64'(head_y) * 64'(FRAME_WIDTH)
                                                 + 64'(head_x));
                        bram_din_d  = head_value;
                        write_inc   = 1'b1;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end else if (swap_pending_q) begin
                    do_swap = 1'b1;
                end
            end
            StClear: begin
                bram_we_d   = 1'b1;
                bram_addr_d = ADDR_BITS'(base_full + 64'(clear_cnt_q));
                bram_din_d  = clear_val_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {pixel_x_in, pixel_y_in, pixel_value_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            front_q        <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            clear_val_q    <= '0;
            clear_cnt_q    <= '0;
            bram_we_q      <= 1'b0;
            bram_addr_q    <= '0;
            bram_din_q     <= '0;
            write_count_q  <= '0;
            drop_count_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            if (push && !pop)      count_q <= count_q + (PTR_BITS+1)'(1);
            else if (pop && !push) count_q <= count_q - (PTR_BITS+1)'(1);

            front_q        <= front_q ^ do_swap;
            swap_done_q    <= do_swap;
            swap_pending_q <= (swap_pending_q | swap_req) & ~do_swap;

            if (clear_start) begin
                clear_val_q <= clear_value;
                clear_cnt_q <= '0;
            end else if (state_q == StClear) begin
                clear_cnt_q <= clear_cnt_q + ADDR_BITS'(1);
            end

            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            if (write_inc) write_count_q <= write_count_q + 32'd1;
            if (drop_inc && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign front_buffer  = front_q;
    assign swap_done     = swap_done_q;
    assign busy_clearing = (state_q == StClear);
    assign bram_we       = bram_we_q;
    assign bram_addr     = bram_addr_q;
    assign bram_din      = bram_din_q;
    assign write_count   = write_count_q;
    assign drop_count    = drop_count_q;
endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer with an 8x4 frame and a 4-entry FIFO.
module tb_framebuffer_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_valid_in = 1'b0;
    logic        pixel_ready_out;
    logic [15:0] pixel_x_in = '0, pixel_y_in = '0, pixel_value_in = '0;
    logic        clear_req = 1'b0;
    logic [15:0] clear_value = '0;
    logic        swap_req = 1'b0;
    logic        front_buffer, swap_done, busy_clearing, bram_we;
    logic [5:0]  bram_addr;
    logic [15:0] bram_din;
    logic [31:0] write_count;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    framebuffer_writer #(
        .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .COORD_BITS(16), .COLOR_WIDTH(16),
        .ADDR_BITS(6), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .pixel_valid_in(pixel_valid_in), .pixel_ready_out(pixel_ready_out),
        .pixel_x_in(pixel_x_in), .pixel_y_in(pixel_y_in), .pixel_value_in(pixel_value_in),
        .clear_req(clear_req), .clear_value(clear_value), .swap_req(swap_req),
        .front_buffer(front_buffer), .swap_done(swap_done), .busy_clearing(busy_clearing),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .write_count(write_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pixel(input logic v, input int x, input int y, input logic [15:0] c);
        pixel_valid_in = v;
        pixel_x_in     = 16'(x);
        pixel_y_in     = 16'(y);
        pixel_value_in = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({pixel_ready_out, front_buffer, swap_done, busy_clearing, bram_we} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000",
                     {pixel_ready_out, front_buffer, swap_done, busy_clearing, bram_we});
        end
        checks++;
        if ({bram_addr, bram_din, write_count, drop_count} !== '0) begin
            errors++;
            $display("FAIL reset_values got addr=%0d din=%h wc=%0d dc=%0d want all 0",
                     bram_addr, bram_din, write_count, drop_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        drive_pixel(1'b1, 3, 2, 16'h0ABC);
        tick();
        drive_pixel(1'b0, 0, 0, 16'h0);
        checks++;
        if (bram_we !== 1'b0) begin
            errors++;
            $display("FAIL single_early_we got %b want 0", bram_we);
        end
        tick();
        checks++;
        if ({bram_we, bram_addr, bram_din, write_count} !== {1'b1, 6'd51, 16'h0ABC, 32'd1}) begin
            errors++;
            $display("FAIL single_write got we=%b addr=%0d din=%h wc=%0d want 1 51 0abc 1",
                     bram_we, bram_addr, bram_din, write_count);
        end
        tick();
        checks++;
        if (bram_we !== 1'b0 || bram_addr !== 6'd51) begin
            errors++;
            $display("FAIL single_after got we=%b addr=%0d want 0 51", bram_we, bram_addr);
        end
    endtask

    task automatic test_drop();
        drive_pixel(1'b1, 8, 0, 16'h1111);
        tick();
        drive_pixel(1'b1, 0, 4, 16'h2222);
        tick();
        drive_pixel(1'b0, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bram_we !== 1'b0) begin
                errors++;
                $display("FAIL drop_we cycle %0d got %b want 0", i, bram_we);
            end
            tick();
        end
        checks++;
        if (drop_count !== 16'd2 || write_count !== 32'd1) begin
            errors++;
            $display("FAIL drop_counts got dc=%0d wc=%0d want 2 1", drop_count, write_count);
        end
    endtask

    task automatic test_clear();
        logic [23:0] got, exp;
        clear_req   = 1'b1;
        clear_value = 16'h0F00;
        tick();
        clear_req   = 1'b0;
        clear_value = 16'h1234;
        checks++;
        if (busy_clearing !== 1'b1 || bram_we !== 1'b0) begin
            errors++;
            $display("FAIL clear_start got busy=%b we=%b want 1 0", busy_clearing, bram_we);
        end
        for (int i = 0; i < 32; i++) begin
            clear_req = (i == 10);
            tick();
            clear_req = 1'b0;
            got = {bram_we, bram_addr, bram_din, busy_clearing};
            exp = {1'b1, 6'(32 + i), 16'h0F00, (i < 31)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clear_sweep step %0d got %h want %h", i, got, exp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bram_we !== 1'b0 || busy_clearing !== 1'b0) begin
                errors++;
                $display("FAIL clear_end cycle %0d got we=%b busy=%b want 0 0",
                         i, bram_we, busy_clearing);
            end
        end
    endtask

    task automatic test_backpressure();
        int waited;
        clear_req   = 1'b1;
        clear_value = 16'h00AA;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_pixel(1'b1, i, 1, 16'(16'h0100 + i));
            tick();
        end
        drive_pixel(1'b1, 7, 3, 16'hDEAD);
        checks++;
        if (pixel_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_ready got %b want 0", pixel_ready_out);
        end
        waited = 0;
        while (busy_clearing === 1'b1 && waited < 60) begin
            tick();
            waited++;
            if (busy_clearing === 1'b1) begin
                checks++;
                if (pixel_ready_out !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready_during_clear got %b want 0", pixel_ready_out);
                end
            end
        end
        drive_pixel(1'b0, 0, 0, 16'h0);
        checks++;
        if (busy_clearing !== 1'b0) begin
            errors++;
            $display("FAIL bp_clear_timeout got busy=%b want 0", busy_clearing);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({bram_we, bram_addr, bram_din} !== {1'b1, 6'(40 + i), 16'(16'h0100 + i)}) begin
                errors++;
                $display("FAIL bp_drain %0d got we=%b addr=%0d din=%h want 1 %0d %h", i,
                         bram_we, bram_addr, bram_din, 40 + i, 16'h0100 + i);
            end
        end
        tick();
        checks++;
        if ({bram_we, pixel_ready_out, write_count} !== {1'b0, 1'b1, 32'd5}) begin
            errors++;
            $display("FAIL bp_after got we=%b ready=%b wc=%0d want 0 1 5",
                     bram_we, pixel_ready_out, write_count);
        end
    endtask

    task automatic test_swap();
        drive_pixel(1'b1, 1, 0, 16'h0A01);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        drive_pixel(1'b1, 2, 0, 16'h0A02);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        checks++;
        if ({bram_we, bram_addr, front_buffer} !== {1'b1, 6'd33, 1'b0}) begin
            errors++;
            $display("FAIL swap_w0 got we=%b addr=%0d front=%b want 1 33 0",
                     bram_we, bram_addr, front_buffer);
        end
        drive_pixel(1'b1, 3, 0, 16'h0A03);
        tick();
        drive_pixel(1'b0, 0, 0, 16'h0);
        checks++;
        if ({bram_we, bram_addr, front_buffer} !== {1'b1, 6'd34, 1'b0}) begin
            errors++;
            $display("FAIL swap_w1 got we=%b addr=%0d front=%b want 1 34 0",
                     bram_we, bram_addr, front_buffer);
        end
        tick();
        checks++;
        if ({bram_we, bram_addr, front_buffer, swap_done} !== {1'b1, 6'd35, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL swap_w2 got we=%b addr=%0d front=%b done=%b want 1 35 0 0",
                     bram_we, bram_addr, front_buffer, swap_done);
        end
        tick();
        checks++;
        if ({bram_we, front_buffer, swap_done} !== 3'b011) begin
            errors++;
            $display("FAIL swap_take got we=%b front=%b done=%b want 0 1 1",
                     bram_we, front_buffer, swap_done);
        end
        drive_pixel(1'b1, 0, 0, 16'h0777);
        tick();
        drive_pixel(1'b0, 0, 0, 16'h0);
        checks++;
        if ({front_buffer, swap_done} !== 2'b10) begin
            errors++;
            $display("FAIL swap_pulse got front=%b done=%b want 1 0", front_buffer, swap_done);
        end
        tick();
        checks++;
        if ({bram_we, bram_addr, bram_din} !== {1'b1, 6'd0, 16'h0777}) begin
            errors++;
            $display("FAIL swap_front_write got we=%b addr=%0d din=%h want 1 0 0777",
                     bram_we, bram_addr, bram_din);
        end
        tick();
        tick();
        checks++;
        if ({front_buffer, swap_done, write_count} !== {1'b1, 1'b0, 32'd9}) begin
            errors++;
            $display("FAIL swap_single got front=%b done=%b wc=%0d want 1 0 9",
                     front_buffer, swap_done, write_count);
        end
    endtask

    task automatic test_reset_mid_clear();
        clear_req   = 1'b1;
        clear_value = 16'h5555;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_pixel(1'b1, i, 0, 16'h0BBB);
            tick();
        end
        drive_pixel(1'b0, 0, 0, 16'h0);
        tick();
        checks++;
        if (bram_we !== 1'b1 || busy_clearing !== 1'b1) begin
            errors++;
            $display("FAIL rmc_pre got we=%b busy=%b want 1 1", bram_we, busy_clearing);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bram_we, front_buffer, busy_clearing, pixel_ready_out} !== 4'b0001) begin
            errors++;
            $display("FAIL rmc_flags got we=%b front=%b busy=%b ready=%b want 0 0 0 1",
                     bram_we, front_buffer, busy_clearing, pixel_ready_out);
        end
        checks++;
        if (write_count !== 32'd0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL rmc_counts got wc=%0d dc=%0d want 0 0", write_count, drop_count);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bram_we !== 1'b0) begin
                errors++;
                $display("FAIL rmc_quiet cycle %0d got we=%b want 0", i, bram_we);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_drop();
        test_clear();
        test_backpressure();
        test_swap();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/framebuffer_writer.md
Name: framebuffer_writer

Overview:
- Parametrised pixel write port between the raytracing controller and the pixel BRAM (port A).
- Accepts (x, y, colour) pixel writes through a valid/ready handshake into a small FIFO and converts each to a linear BRAM address.
- Adds double buffering with a frame-boundary swap, a hardware clear sweep, bounds checking with a drop counter, and a write counter for the seven-segment debug display.

Parameters:
- FRAME_WIDTH, 512, pixels per row.
- FRAME_HEIGHT, 384, rows per buffer.
- COORD_BITS, 16, width of x/y inputs.
- COLOR_WIDTH, 16, padded pixel word width.
- ADDR_BITS, 19, BRAM address width; must satisfy 2^ADDR_BITS >= 2*FRAME_WIDTH*FRAME_HEIGHT.
- FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- pixel_valid_in  in  1  pixel offered.
- pixel_ready_out  out  1  FIFO can accept.
- pixel_x_in  in  COORD_BITS  pixel column.
- pixel_y_in  in  COORD_BITS  pixel row.
- pixel_value_in  in  COLOR_WIDTH  pixel colour.
- clear_req  in  1  one-cycle pulse: fill the back buffer with clear_value.
- clear_value  in  COLOR_WIDTH  fill colour, sampled on an accepted clear_req.
- swap_req  in  1  one-cycle pulse: exchange front and back buffers.
- front_buffer  out  1  buffer index the display reads.
- swap_done  out  1  one-cycle pulse when a swap takes effect.
- busy_clearing  out  1  clear sweep in progress.
- bram_we  out  1  BRAM write enable (registered).
- bram_addr  out  ADDR_BITS  BRAM address (registered).
- bram_din  out  COLOR_WIDTH  BRAM data (registered).
- write_count  out  32  pixel writes committed; wraps.
- drop_count  out  16  out-of-range pixels discarded; saturates at 0xFFFF.

Behaviour:
- Reset:
  - FIFO empty; pixel_ready_out=1; front_buffer=0; all other outputs 0.
  - FSM to IDLE; pending swap and clear flags cleared.
  - Reset mid-clear or mid-drain aborts immediately, with no further writes.
- Handshake:
  - Push when pixel_valid_in && pixel_ready_out.
  - pixel_ready_out = !fifo_full, taken from registered count.
  - Push is allowed in every FSM state, including CLEAR.
- Address computation:
  - back = ~front_buffer; base = back * FRAME_WIDTH*FRAME_HEIGHT.
  - addr = base + y*FRAME_WIDTH + x, computed at full width, then truncated to ADDR_BITS.
- FSM has two states, IDLE and CLEAR. Priority each cycle, highest first: clear, pixel drain, swap.
- IDLE, in priority order:
  - clear_req: latch clear_value, counter=0, go to CLEAR, busy_clearing=1 next cycle. No pixel pop that cycle.
  - Else FIFO non-empty: pop head.
    - If x<FRAME_WIDTH and y<FRAME_HEIGHT: next cycle bram_we=1, bram_addr=addr, bram_din=value, write_count+1.
    - Otherwise no write and drop_count+1 (saturating).
    - Exactly one pop per cycle.
  - Else swap pending: front_buffer toggles, swap_done=1 for one cycle, pending flag cleared.
- CLEAR:
  - Each cycle: bram_we=1, bram_addr=base+counter, bram_din=latched value.
  - Runs for exactly FRAME_WIDTH*FRAME_HEIGHT cycles, then returns to IDLE; busy_clearing deasserts the cycle after the last clear write.
  - The FIFO fills but does not drain during CLEAR.
  - Clear writes do not increment write_count.
  - clear_req in CLEAR is ignored.
- swap_req:
  - Sets a pending flag in any state; a second swap_req while pending is absorbed (one swap only).
  - A swap never occurs while the FIFO is non-empty or in CLEAR, so a frame never straddles buffers.
- Latency:
  - Accept in cycle N into an empty FIFO in IDLE with no clear or swap gives bram_we in cycle N+2: pop in N+1, registered output in N+2.
  - Sustained throughput is 1 pixel per cycle.
- Simultaneous push and pop leaves the count unchanged. When full, ready is low, so no push occurs.
- bram_we is 0 in every cycle without a pixel write or clear write. bram_addr and bram_din hold their last values.

Test Plan (FRAME_WIDTH=8, FRAME_HEIGHT=4, FIFO_DEPTH=4):
- Reset, then push (x=3, y=2, 0x0ABC) -> bram_we two cycles later with addr=32+19=51 (back buffer 1), din=0x0ABC, write_count=1.
- Push (8,0) then (0,4) -> no bram_we, drop_count=2, write_count unchanged.
- Hold pixel_valid_in high with ready ignored by the sink, while bram is stalled by a clear -> after 4 pushes pixel_ready_out=0. After the clear, 4 writes on consecutive cycles, then ready=1.
- clear_req with clear_value=0x0F00 in front_buffer=0 state -> 32 consecutive writes, addr 32..63, din 0x0F00. busy_clearing high exactly 32 cycles. clear_req mid-sweep is ignored.
- swap_req with 3 pixels queued -> 3 writes to buffer 1, then front_buffer=1 with swap_done pulse. The next pixel (0,0) goes to addr 0. Double swap_req gives a single toggle.
- rst asserted mid-clear -> bram_we=0 next cycle, front_buffer=0, counters 0, pixel_ready_out=1.
